// File: rtl/sha256_msg_padder_pkg.sv
// Shared SHA-256 constants and types for the message padder and sha256_512top.
package sha256_pkg;

    localparam int SHA_WORD_W  = 32;
    localparam int SHA_BLOCK_W = 512;
    localparam int SHA_WORDS   = 16;

    localparam logic [7:0]            SHA_PAD_BYTE = 8'h80;
    localparam logic [SHA_WORD_W-1:0] SHA_PAD_WORD = {SHA_PAD_BYTE, 24'h0};

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        EXTRA
    } padder_state_e;

    // Word i sits in bits [32i+31:32i] of the flattened block.
    typedef logic [SHA_WORDS-1:0][SHA_WORD_W-1:0] sha_block_t;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word input stream and block output stream of the SHA-256 message padder.
interface sha256_msg_padder_if;

    logic [sha256_pkg::SHA_WORD_W-1:0]  in_data;
    logic [1:0]                         in_bytes;
    logic                               in_last;
    logic                               in_valid;
    logic                               in_ready;
    logic [sha256_pkg::SHA_BLOCK_W-1:0] out_block;
    logic                               out_first;
    logic                               out_last;
    logic                               out_valid;
    logic                               out_ready;

    modport slave (
        input  in_data, in_bytes, in_last, in_valid, out_ready,
        output in_ready, out_block, out_first, out_last, out_valid
    );

    modport master (
        output in_data, in_bytes, in_last, in_valid, out_ready,
        input  in_ready, out_block, out_first, out_last, out_valid
    );

endinterface

// File: rtl/sha256_pad_word.sv
// Masks the unused bytes of a closing word and inserts the 0x80 pad byte;
// spill_o flags a full word whose pad byte belongs in the following word.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [SHA_WORD_W-1:0] data_i,
    input  logic [1:0]            bytes_i,
    output logic [SHA_WORD_W-1:0] word_o,
    output logic                  spill_o
);

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        word_o  = data_i;
        spill_o = 1'b0;
        unique case (bytes_i)
            2'd1:    word_o = {data_i[31:24], SHA_PAD_BYTE, 16'h0};
            2'd2:    word_o = {data_i[31:16], SHA_PAD_BYTE, 8'h0};
            2'd3:    word_o = {data_i[31:8], SHA_PAD_BYTE};
            default: spill_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 padder: packs 32-bit words into one block buffer, appends
// 0x80, zero fill and the bit length, and emits framed 512-bit blocks.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    sha256_msg_padder_if.slave  bus
);

    padder_state_e    state_q, state_d;
    logic [3:0]       widx_q, widx_d;
    logic [LEN_W-1:0] len_q, len_d;
    sha_block_t       block_q, block_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;
    logic             first_pend_q, first_pend_d;
    logic             extra_q, extra_d;
    logic             spill_q, spill_d;

    logic [SHA_WORD_W-1:0] pad_word;
    logic                  pad_full;
    logic                  in_ready;
    logic                  accept;
    logic [5:0]            add_bits;
    logic [63:0]           len_ext_d, len_ext_q;
    int                    k;

    sha256_pad_word u_pad_word (
        .data_i  (bus.in_data),
        .bytes_i (bus.in_bytes),
        .word_o  (pad_word),
        .spill_o (pad_full)
    );

    assign in_ready      = (state_q == FILL) && rst;
    assign accept        = in_ready && bus.in_valid;
    assign add_bits      = (!bus.in_last || bus.in_bytes == 2'd0) ? 6'd32
                                                                  : {1'b0, bus.in_bytes, 3'b000};
    assign len_ext_q     = 64'(len_q);
    assign len_ext_d     = 64'(len_d);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_block = block_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;

    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        len_d        = len_q;
        block_d      = block_q;
        out_first_d  = out_first_q;
        out_last_d   = out_last_q;
        first_pend_d = first_pend_q;
        extra_d      = extra_q;
        spill_d      = spill_q;
        k            = int'(widx_q);

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    len_d  = len_q + LEN_W'(add_bits);
                    widx_d = widx_q + 4'd1;
                    if (!bus.in_last) begin
                        block_d[widx_q] = bus.in_data;
                        if (widx_q == 4'd15) begin
                            out_first_d = first_pend_q;
                            out_last_d  = 1'b0;
                            state_d     = EMIT;
                        end
                    end else begin
                        for (int i = 0; i < SHA_WORDS; i++) begin
                            if (i == k)                       block_d[i] = pad_word;
                            else if (i == k + 1 && pad_full)  block_d[i] = SHA_PAD_WORD;
                            else if (i > k)                   block_d[i] = '0;
                        end
                        // Length fits only if the pad byte landed in word 13 or earlier.
                        if (pad_full ? (widx_q <= 4'd12) : (widx_q <= 4'd13)) begin
                            block_d[14] = len_ext_d[63:32];
                            block_d[15] = len_ext_d[31:0];
                            out_last_d  = 1'b1;
                        end else begin
                            out_last_d  = 1'b0;
                            extra_d     = 1'b1;
                            spill_d     = pad_full && (widx_q == 4'd15);
                        end
                        out_first_d = first_pend_q;
                        widx_d      = '0;
                        state_d     = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    first_pend_d = out_last_q;
                    if (extra_q) begin
                        state_d = EXTRA;
                    end else begin
                        state_d = FILL;
                        widx_d  = '0;
                        if (out_last_q) len_d = '0;
                    end
                end
            end
            EXTRA: begin
                block_d     = '0;
                block_d[0]  = spill_q ? SHA_PAD_WORD : '0;
                block_d[14] = len_ext_q[63:32];
                block_d[15] = len_ext_q[31:0];
                out_first_d = 1'b0;
                out_last_d  = 1'b1;
                extra_d     = 1'b0;
                spill_d     = 1'b0;
                state_d     = EMIT;
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            widx_q       <= '0;
            len_q        <= '0;
            // NOTE: the block buffer is reset because it drives out_block directly.
            block_q      <= '0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            first_pend_q <= 1'b1;
            extra_q      <= 1'b0;
            spill_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            len_q        <= len_d;
            block_q      <= block_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            first_pend_q <= first_pend_d;
            extra_q      <= extra_d;
            spill_q      <= spill_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder: a byte-level FIPS 180-4 padding model
// predicts every block, plus directed boundary, backpressure and reset cases.
module tb_sha256_msg_padder;

    typedef struct packed {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    logic clk;
    logic rst;

    sha256_msg_padder_if bus ();

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    exp_t         exp_q[$];
    bit           auto_sink = 1'b1;
    logic [511:0] last_blk;
    logic         last_first;
    logic         last_last;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference padding: byte list -> 0x80 -> zeros to 56 mod 64 -> 64-bit big-endian length.
    task automatic model_msg(input logic [7:0] msg[$]);
        logic [7:0]      p[$];
        longint unsigned bits;
        int              nblk;
        exp_t            e;
        bits = 64'(msg.size()) * 8;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int w = 0; w < 16; w++)
                for (int j = 0; j < 4; j++)
                    e.blk[32*w + 8*(3-j) +: 8] = p[64*b + 4*w + j];
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input logic [1:0] nb, input logic last);
        int t = 0;
        @(negedge clk);
        bus.in_data  = d;
        bus.in_bytes = nb;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Unused bytes of the closing word carry random garbage the padder must mask.
    task automatic drive_msg(input logic [7:0] msg[$]);
        int nw = (msg.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int          nb;
            d  = $urandom;
            nb = msg.size() - 4*w;
            if (nb > 4) nb = 4;
            for (int j = 0; j < nb; j++) d[8*(3-j) +: 8] = msg[4*w + j];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_word(d, 2'(nb % 4), w == nw - 1);
        end
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        model_msg(msg);
        drive_msg(msg);
    endtask

    task automatic rand_msg(input int len, output logic [7:0] msg[$]);
        msg = {};
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    task automatic take_block();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_block", 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check("block", bus.out_block, e.blk);
            check("first", bus.out_first, e.first);
            check("last", bus.out_last, e.last);
        end
        last_blk   = bus.out_block;
        last_first = bus.out_first;
        last_last  = bus.out_last;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain", 512'(exp_q.size()), '0);
        @(negedge clk);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_sink) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                if (bus.out_valid && bus.out_ready) take_block();
            end
        end
    end

    initial begin
        logic [7:0] msg[$];
        logic [7:0] abc[$];
        logic [7:0] xyz[$];
        abc = '{8'h61, 8'h62, 8'h63};
        xyz = '{8'h78, 8'h79, 8'h7a};

        rst          = 1'b0;
        bus.in_data  = '0;
        bus.in_bytes = '0;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_block", bus.out_block, '0);
        check("rst_out_first", bus.out_first, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1'b1);

        // "abc" fits in one block.
        send_msg(abc);
        wait_drain();
        check("abc_block", last_blk, {32'h00000018, 448'h0, 32'h61626380});
        check("abc_first", last_first, 1'b1);
        check("abc_last", last_last, 1'b1);

        // 512-bit message: pad byte spills into word 0 of the extra block.
        rand_msg(64, msg);
        send_msg(msg);
        wait_drain();
        check("w16_extra", last_blk, {32'h00000200, 448'h0, 32'h80000000});
        check("w16_extra_first", last_first, 1'b0);

        // 448 bits: pad byte in word 14, length only in the extra block.
        rand_msg(56, msg);
        send_msg(msg);
        wait_drain();
        check("w14_extra", last_blk, {32'h000001C0, 480'h0});

        // 440 bits: pad byte in word 13, length fits.
        rand_msg(55, msg);
        send_msg(msg);
        wait_drain();
        check("w14p_len", last_blk[511:480], 32'h000001B8);
        check("w14p_w14", last_blk[479:448], 32'h0);
        check("w14p_pad", last_blk[423:416], 8'h80);
        check("w14p_last", last_last, 1'b1);

        // Every boundary length around one block, then random lengths.
        for (int i = 0; i < 40; i++) begin
            rand_msg((i < 18) ? 48 + i : $urandom_range(1, 150), msg);
            send_msg(msg);
        end
        wait_drain();

        // Backpressure with a word held at the input.
        auto_sink     = 1'b0;
        bus.out_ready = 1'b0;
        send_msg(abc);
        model_msg(xyz);
        @(negedge clk);
        bus.in_data  = 32'h78797a55;
        bus.in_bytes = 2'd3;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.out_valid, 1'b1);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_block", bus.out_block, exp_q[0].blk);
            check("bp_first", bus.out_first, exp_q[0].first);
            check("bp_last", bus.out_last, exp_q[0].last);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        take_block();
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_ready_after", bus.in_ready, 1'b1);
        check("bp_valid_after", bus.out_valid, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_held_latency", bus.out_valid, 1'b1);
        auto_sink = 1'b1;
        wait_drain();

        // Asynchronous reset in the middle of a message.
        for (int i = 0; i < 7; i++) drive_word($urandom, 2'd0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b0);
        check("mid_rst_block", bus.out_block, '0);
        check("mid_rst_first", bus.out_first, 1'b0);
        check("mid_rst_last", bus.out_last, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        send_msg(abc);
        wait_drain();
        check("post_rst_block", last_blk, {32'h00000018, 448'h0, 32'h61626380});
        check("post_rst_first", last_first, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Streaming front end that turns a raw 32-bit message stream into SHA-256 padded 512-bit blocks for sha256_512top.
- Accumulates words into a single block buffer.
- Appends the 0x80 byte, zero fill and a 64-bit bit-length per FIPS 180-4.
- Emits blocks with first/last framing over a valid/ready handshake.

Parameters:
LEN_W, 64, width of the internal bit-length counter; zero-extended into the 64-bit length field; legal range 16..64.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_data  in  32  message word; byte 0 of the word in bits [31:24]
in_bytes  in  2  valid bytes in the last word (0 means 4); ignored unless in_last
in_last  in  1  final word of the message
in_valid  in  1  word available
in_ready  out  1  padder accepts the word this cycle
out_block  out  512  padded block; word i in bits [32i+31:32i]
out_first  out  1  block is the first block of its message
out_last  out  1  block is the final block (carries the length)
out_valid  out  1  block available
out_ready  in  1  sha256_512top consumes the block this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_block=0, out_first=0, out_last=0, in_ready=0.
  - Word index and length counter cleared; state FILL.
  - Any partial block or pending output is discarded.
- States: FILL, EMIT, EXTRA.
- FILL:
  - in_ready=1.
  - A word is accepted when in_valid&&in_ready and written to word[widx]; widx then increments.
  - Length adds 32 per non-last word; on the last word it adds 8*in_bytes (4 when in_bytes=0).
  - Non-last word at widx=15 -> EMIT, out_last=0.
- Last word at index k:
  - Bytes beyond in_bytes are zeroed.
  - 0x80 goes in the first byte after the data: inside word k if partial, or at word k+1 bits [31:24] if full.
  - All following words are zero.
  - If the 0x80 lands in word<=13: word14 = len[63:32], word15 = len[31:0], out_last=1 -> EMIT.
  - Otherwise (the 0x80 lands in word 14 or 15, or spills past word 15): emit the block with out_last=0 and set pending_extra -> EMIT.
  - If a full last word arrives at widx=15, the 0x80 goes into word 0 of the extra block.
- EMIT:
  - out_valid=1 and in_ready=0.
  - out_block, out_first and out_last are held stable until out_valid&&out_ready.
  - On handshake: if pending_extra -> EXTRA. Otherwise -> FILL with widx=0; length cleared if out_last.
- EXTRA:
  - Builds the extra block: words 0..13 zero, except word0=0x80000000 when the spill case applies; word14/15 = length.
  - Sets out_last=1 and out_first=0, then goes to EMIT.
- out_first is 1 on the first block emitted after reset or after a block with out_last=1, and 0 otherwise.
- Latency: block valid on the cycle after the edge that accepts its closing word; EXTRA costs one further cycle.
- Minimum gap: 1 idle cycle between blocks (single buffer, no overlap of fill and emit).
- Zero-length messages are not supported.
- Messages over 2^LEN_W-1 bits wrap the counter modulo 2^LEN_W.
- Simultaneous in_valid during EMIT/EXTRA: the word is not accepted and must be held by the source.

Decomposition:
- sha256_pkg holds:
  - SHA_WORD_W=32, SHA_BLOCK_W=512, SHA_WORDS=16, SHA_PAD_BYTE=8'h80;
  - padder state enum {FILL, EMIT, EXTRA};
  - shared with sha256_512top.
- One combinational sub-module, sha256_pad_word: in_data and in_bytes -> masked word with 0x80 inserted, plus a spill flag.

Test Plan:
1. "abc": one word 32'h61626300, in_bytes=3, in_last -> single block {32'h00000018, 448'h0, 32'h61626380}, out_first=1, out_last=1.
2. 16 full words (512 bits), last at widx=15 -> block 1 = data (first=1, last=0), then block 2 = {32'h00000200, 448'h0, 32'h80000000} (first=0, last=1).
3. 14 full words, last full -> block 1: word14=32'h80000000, word15=0, last=0; block 2: words0..14=0, word15=32'h000001C0, last=1.
4. 14 words, last in_bytes=3 (440 bits) -> single block: word13 low byte 0x80, word14=0, word15=32'h000001B8, last=1.
5. Backpressure: out_ready low 5 cycles after out_valid -> out_block/out_first/out_last unchanged, in_ready=0 with in_valid=1 held; out_ready high -> handshake, in_ready=1 next cycle, held word accepted.
6. Assert rst=0 after 7 words of a message -> outputs at reset values immediately; a new "abc" message then yields test 1's block exactly, with out_first=1.
